// File: rtl/dmem_bus_if.sv
// Data-memory bus interface: turns MEM-stage requests into single classic Wishbone cycles.
// Define DMEM_TIMEOUT_EN to terminate accesses that see no ack within TIMEOUT_CYCLES.
module dmem_bus_if #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ce_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [3:0]        cpu_sel_i,
    input  logic [31:0]       cpu_data_i,
    output logic [31:0]       cpu_data_o,
    output logic              stallreq_o,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [3:0]        wb_sel_o,
    output logic [31:0]       wb_dat_o,
    input  logic [31:0]       wb_dat_i,
    input  logic              wb_ack_i,
    output logic              err_o
);

    localparam int unsigned CNT_W =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] rd_buf;
    logic        flushed;
    logic        tmo;
    logic        done;
    logic        discard;
    logic        unused_ok;

    assign unused_ok = &{1'b0, cpu_addr_i[1:0]};

`ifdef DMEM_TIMEOUT_EN
    logic [CNT_W-1:0] tmo_cnt;

    // Counts BUSY cycles without ack; held clear while idle so every access starts at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == IDLE) begin
            tmo_cnt <= '0;
        end else if (state == BUSY && !wb_ack_i) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    assign tmo   = (state == BUSY) && !wb_ack_i && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign err_o = tmo & ~rst;
`else
    logic [CNT_W-1:0] unused_tmo_cnt;

    assign unused_tmo_cnt = '0;
    assign tmo            = 1'b0;
    assign err_o          = 1'b0;
`endif

    // Access ends this cycle, either by ack or by timeout.
    assign done    = (state == BUSY) && (wb_ack_i || tmo);
    // Stores and flushed loads never return data to the pipeline.
    assign discard = flushed || flush_i || wb_we_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        stallreq_o = 1'b0;
        cpu_data_o = 32'h0;
        case (state)
            IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    stallreq_o = 1'b1;
                    state_nxt  = BUSY;
                end
            end
            BUSY: begin
                stallreq_o = ~done;
                if (wb_ack_i && !discard) begin
                    cpu_data_o = wb_dat_i;
                end
                if (done) begin
                    state_nxt = (stall_i && !(flushed || flush_i)) ? HOLD : IDLE;
                end
            end
            HOLD: begin
                cpu_data_o = wb_we_o ? 32'h0 : rd_buf;
                if (flush_i || !stall_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (rst) begin
            state_nxt  = IDLE;
            stallreq_o = 1'b0;
            cpu_data_o = 32'h0;
        end
    end

    // Bus-side registers, read buffer and the sticky flush marker for the current access.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_sel_o <= 4'h0;
            wb_dat_o <= 32'h0;
            rd_buf   <= 32'h0;
            flushed  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_ce_i && !flush_i) begin
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= cpu_we_i;
                        wb_adr_o <= {cpu_addr_i[ADDR_W-1:2], 2'b00};
                        wb_sel_o <= cpu_sel_i;
                        wb_dat_o <= cpu_data_i;
                        flushed  <= 1'b0;
                    end
                end
                BUSY: begin
                    if (flush_i) begin
                        flushed <= 1'b1;
                    end
                    if (done) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        if (!discard) begin
                            rd_buf <= wb_ack_i ? wb_dat_i : 32'h0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_if.sv
// Self-checking bench for dmem_bus_if: directed vector table, hand sequences, randomized accesses.
module tb_dmem_bus_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic        stall_i;
    logic        flush_i;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        err_o;

    int n_chk  = 0;
    int n_fail = 0;

    dmem_bus_if #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_sel_i  (cpu_sel_i),
        .cpu_data_i (cpu_data_i),
        .cpu_data_o (cpu_data_o),
        .stallreq_o (stallreq_o),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_sel_o   (wb_sel_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
        int          wait_n;     // BUSY cycles before the ack cycle
        int          hold;       // -1: stall_i low at ack; else extra stalled HOLD cycles
        int          flush_at;   // BUSY cycle index carrying flush_i, 0 = none
        logic [31:0] ack_data;
        logic [31:0] exp_adr;
        int          exp_stall;
        logic [31:0] exp_ack_data;
        logic        exp_hold;
        logic [31:0] exp_hold_data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_ce_i   = 1'b0;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0;
        cpu_sel_i  = 4'h0;
        cpu_data_i = 32'h0;
        stall_i    = 1'b0;
        flush_i    = 1'b0;
        wb_ack_i   = 1'b0;
        wb_dat_i   = 32'h0;
    endtask

    // Reference model: expected outcome of one access from the interface rules alone.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        logic flushed;
        r               = v;
        flushed         = (v.flush_at != 0);
        r.exp_adr       = v.addr & 32'hFFFF_FFFC;
        r.exp_stall     = v.wait_n + 1;
        r.exp_ack_data  = (v.we || flushed) ? 32'h0 : v.ack_data;
        r.exp_hold      = (v.hold >= 0) && !flushed;
        r.exp_hold_data = v.we ? 32'h0 : v.ack_data;
        return r;
    endfunction

    task automatic run_access(input vec_t v);
        int stalls;
        stalls     = 0;
        cpu_ce_i   = 1'b1;
        cpu_we_i   = v.we;
        cpu_addr_i = v.addr;
        cpu_sel_i  = v.sel;
        cpu_data_i = v.data;
        stall_i    = 1'b0;
        flush_i    = 1'b0;
        wb_ack_i   = 1'b0;
        #2;
        if (stallreq_o) stalls++;
        chk("req_cyc", 32'(wb_cyc_o), 32'h0);
        chk("req_cpu_data", cpu_data_o, 32'h0);
        step();
        for (int k = 1; k <= v.wait_n + 1; k++) begin
            wb_ack_i = (k == v.wait_n + 1);
            wb_dat_i = wb_ack_i ? v.ack_data : $urandom;
            flush_i  = (k == v.flush_at);
            stall_i  = wb_ack_i ? (v.hold >= 0) : 1'b1;
            #2;
            if (stallreq_o) stalls++;
            chk("busy_cyc_stb", {30'h0, wb_cyc_o, wb_stb_o}, 32'h3);
            chk("busy_err", 32'(err_o), 32'h0);
            if (k == 1 || wb_ack_i) begin
                chk("busy_adr", wb_adr_o, v.exp_adr);
                chk("busy_sel_we", {27'h0, wb_we_o, wb_sel_o}, {27'h0, v.we, v.sel});
                chk("busy_dat", wb_dat_o, v.data);
            end
            if (wb_ack_i) chk("ack_cpu_data", cpu_data_o, v.exp_ack_data);
            step();
        end
        wb_ack_i = 1'b0;
        flush_i  = 1'b0;
        chk("stall_cycles", 32'(stalls), 32'(v.exp_stall));
        if (v.exp_hold) begin
            for (int h = 0; h <= v.hold; h++) begin
                stall_i = (h < v.hold);
                #2;
                chk("hold_cpu_data", cpu_data_o, v.exp_hold_data);
                chk("hold_stallreq", 32'(stallreq_o), 32'h0);
                chk("hold_no_reissue", 32'(wb_cyc_o), 32'h0);
                step();
            end
        end
        cpu_ce_i = 1'b0;
        stall_i  = 1'b1;
        #2;
        chk("post_cyc", 32'(wb_cyc_o), 32'h0);
        chk("post_cpu_data", cpu_data_o, 32'h0);
        chk("post_stallreq", 32'(stallreq_o), 32'h0);
        step();
        stall_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        vec_t rv;

        // we, addr, sel, data, wait, hold, flush_at, ack_data | exp_adr, exp_stall, exp_ack, exp_hold, exp_hold_data
        tbl[0] = '{1'b0, 32'h0000_0104, 4'b1111, 32'h0, 3, -1, 0, 32'hDEAD_BEEF,
                   32'h0000_0104, 4, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 32'h0000_0003, 4'b1000, 32'h5A5A_5A5A, 0, -1, 0, 32'h7777_7777,
                   32'h0000_0000, 1, 32'h0, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 32'h2000_0046, 4'b1100, 32'h0, 1, 2, 0, 32'hCAFE_F00D,
                   32'h2000_0044, 2, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D};
        tbl[3] = '{1'b0, 32'h0000_0080, 4'b1111, 32'h0, 2, 0, 1, 32'h1234_5678,
                   32'h0000_0080, 3, 32'h0, 1'b0, 32'h0};
        tbl[4] = '{1'b1, 32'hFFFF_FFFE, 4'b1100, 32'hBEEF_BEEF, 2, 1, 0, 32'hA5A5_0001,
                   32'hFFFF_FFFC, 3, 32'h0, 1'b1, 32'h0};
        tbl[5] = '{1'b0, 32'h0000_0010, 4'b0001, 32'h0, 0, -1, 1, 32'h1111_2222,
                   32'h0000_0010, 1, 32'h0, 1'b0, 32'h0};

        idle_inputs();
        rst      = 1'b1;
        cpu_ce_i = 1'b1;
        step();
        #2;
        chk("rst_bus", {wb_cyc_o, wb_stb_o, wb_we_o, 1'b0, wb_sel_o, 24'h0}, 32'h0);
        chk("rst_adr", wb_adr_o, 32'h0);
        chk("rst_dat", wb_dat_o, 32'h0);
        chk("rst_stallreq", 32'(stallreq_o), 32'h0);
        chk("rst_cpu_data", cpu_data_o, 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        step();
        rst      = 1'b0;
        cpu_ce_i = 1'b0;
        step();

        for (int i = 0; i < 6; i++) run_access(tbl[i]);

        // Flush while in HOLD returns to IDLE even though the pipeline stays stalled.
        rv = model('{1'b0, 32'h0000_0040, 4'b1111, 32'h0, 0, 0, 0, 32'h0BAD_F00D,
                     32'h0, 0, 32'h0, 1'b0, 32'h0});
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = rv.addr; cpu_sel_i = rv.sel;
        step();
        wb_ack_i = 1'b1; wb_dat_i = rv.ack_data; stall_i = 1'b1;
        #2;
        chk("hflush_ack_data", cpu_data_o, 32'h0BAD_F00D);
        step();
        wb_ack_i = 1'b0; flush_i = 1'b1;
        #2;
        chk("hflush_hold_data", cpu_data_o, 32'h0BAD_F00D);
        step();
        flush_i = 1'b0; cpu_ce_i = 1'b0;
        #2;
        chk("hflush_idle_data", cpu_data_o, 32'h0);
        chk("hflush_idle_cyc", 32'(wb_cyc_o), 32'h0);
        step();
        stall_i = 1'b0;

        // Reset in the middle of a bus cycle abandons it; a late ack is ignored.
        cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h0000_0200; cpu_sel_i = 4'hF;
        cpu_data_i = 32'h1357_9BDF;
        step();
        stall_i = 1'b1;
        #2;
        chk("mrst_busy_cyc", 32'(wb_cyc_o), 32'h1);
        rst = 1'b1;
        step();
        #1;
        chk("mrst_bus", {wb_cyc_o, wb_stb_o, wb_we_o, 1'b0, wb_sel_o, 24'h0}, 32'h0);
        chk("mrst_adr", wb_adr_o, 32'h0);
        chk("mrst_dat", wb_dat_o, 32'h0);
        chk("mrst_stallreq", 32'(stallreq_o), 32'h0);
        chk("mrst_cpu_data", cpu_data_o, 32'h0);
        step();
        rst = 1'b0; cpu_ce_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
        #2;
        chk("late_ack_data", cpu_data_o, 32'h0);
        chk("late_ack_stallreq", 32'(stallreq_o), 32'h0);
        step();
        wb_ack_i = 1'b0; stall_i = 1'b0;
        #2;
        chk("late_ack_cyc", 32'(wb_cyc_o), 32'h0);
        step();

`ifdef DMEM_TIMEOUT_EN
        // No ack at all: fourth BUSY cycle terminates with a one-cycle error pulse.
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0300; cpu_sel_i = 4'hF;
        step();
        stall_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            wb_dat_i = 32'hABCD_0000 + 32'(k);
            #2;
            chk("tmo_err", 32'(err_o), 32'(k == 4));
            chk("tmo_stallreq", 32'(stallreq_o), 32'(k != 4));
            chk("tmo_cyc", 32'(wb_cyc_o), 32'h1);
            if (k == 4) chk("tmo_cpu_data", cpu_data_o, 32'h0);
            step();
        end
        stall_i = 1'b0;
        #2;
        chk("tmo_after_cyc", 32'(wb_cyc_o), 32'h0);
        chk("tmo_after_err", 32'(err_o), 32'h0);
        chk("tmo_after_data", cpu_data_o, 32'h0);
        step();
        cpu_ce_i = 1'b0;
        step();
`endif

        for (int i = 0; i < 40; i++) begin
            rv          = '{default: 0};
            rv.we       = 1'($urandom_range(0, 1));
            rv.addr     = $urandom;
            rv.sel      = 4'($urandom_range(1, 15));
            rv.data     = $urandom;
            rv.wait_n   = $urandom_range(0, 3);
            rv.hold     = int'($urandom_range(0, 3)) - 1;
            rv.flush_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, rv.wait_n + 1)) : 0;
            rv.ack_data = $urandom;
            run_access(model(rv));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_bus_if.md
Name: dmem_bus_if

Overview:
- Data-memory bus interface directly downstream of the MEM stage.
- Takes the MEM stage's per-cycle memory request (ce/we/sel/addr/data) and runs it as a single Wishbone-style classic bus cycle, with wait states.
- Holds the pipeline via stallreq_o until the bus acknowledges.
- Returns the raw 32-bit read word to the MEM stage, which does byte/half extraction and sign extension.

Parameters:
- ADDR_W, 32, address width of CPU and bus side.
- TIMEOUT_CYCLES, 255, max wait for wb_ack_i. Used only with DMEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset.
- cpu_ce_i  in  1  memory request from MEM stage.
- cpu_we_i  in  1  1=store, 0=load.
- cpu_addr_i  in  ADDR_W  byte address.
- cpu_sel_i  in  4  byte-lane enables.
- cpu_data_i  in  32  store data, already lane-replicated.
- cpu_data_o  out  32  read word to MEM stage.
- stallreq_o  out  1  stall request to pipeline controller.
- stall_i  in  1  pipeline held this cycle by any source.
- flush_i  in  1  pipeline flush (exception).
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  bus strobe.
- wb_we_o  out  1  bus write.
- wb_adr_o  out  ADDR_W  word-aligned address.
- wb_sel_o  out  4  bus byte lanes.
- wb_dat_o  out  32  bus write data.
- wb_dat_i  in  32  bus read data.
- wb_ack_i  in  1  bus acknowledge.
- err_o  out  1  timeout pulse.

Behaviour:
- Reset: rst is synchronous, active-high. On reset:
  - state=IDLE.
  - wb_cyc_o/stb_o/we_o=0; wb_adr_o/sel_o/dat_o=0.
  - rd_buf=0; err_o=0.
  - stallreq_o=0 and cpu_data_o=0 while rst=1.
- A reset mid-transaction abandons the cycle immediately: cyc/stb drop on the next edge.
- States: IDLE, BUSY, HOLD.
- IDLE:
  - stallreq_o = cpu_ce_i & ~flush_i, combinationally, in the same cycle.
  - On that condition, at the edge: register wb_adr_o={cpu_addr_i[ADDR_W-1:2],2'b00}, wb_sel_o=cpu_sel_i, wb_we_o=cpu_we_i, wb_dat_o=cpu_data_i; cyc=stb=1; go to BUSY.
  - cpu_data_o=0 in IDLE.
- BUSY:
  - Bus signals held stable.
  - stallreq_o = ~wb_ack_i.
  - In the ack cycle, cpu_data_o = wb_dat_i (combinational bypass), so the MEM stage completes with zero extra latency.
  - At the ack edge: cyc=stb=0; rd_buf<=wb_dat_i; go to HOLD if stall_i=1, else IDLE.
- HOLD:
  - stallreq_o=0; cpu_data_o=rd_buf.
  - The request is not reissued, even though cpu_ce_i stays high while the pipeline is stalled.
  - Go to IDLE on the first cycle with stall_i=0. rd_buf is still driven during that cycle.
- Minimum load/store latency: 1 request cycle + N wait cycles. The access completes in the ack cycle.
- Back-to-back requests: IDLE is re-entered after ack, so the next request starts on the following cycle. There is one idle bus cycle between accesses.
- flush_i:
  - In IDLE: suppresses the new request.
  - In BUSY: the bus cycle still runs to ack (no abort). Read data is discarded (rd_buf not updated, cpu_data_o=0). stallreq_o remains asserted until ack. Next state is IDLE regardless of stall_i.
  - In HOLD: go to IDLE.
- Stores: cpu_data_o=0 throughout; rd_buf unchanged.
- Misaligned sel/addr combinations are passed through unchanged; alignment checking happens upstream.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined:
  - 8-bit+ counter cleared on entry to BUSY, incremented each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES with no ack, treat that cycle as a terminated access: stallreq_o=0, cpu_data_o=32'h0, err_o=1 for exactly one cycle. Then cyc/stb=0 and state transitions as for ack, with rd_buf<=0.
  - An ack in the same cycle as expiry wins: normal completion, err_o=0.
- Not defined: no counter; err_o tied 0; BUSY waits indefinitely.

Test Plan:
- LW at addr 0x0000_0104, bus acks after 3 wait cycles with 0xDEADBEEF:
  - wb_adr_o=0x104, sel=4'b1111, stallreq_o high 4 cycles.
  - cpu_data_o=0xDEADBEEF in ack cycle; back to IDLE next cycle.
- SB at 0x0000_0003, data 0x5A5A5A5A, sel=4'b1000, ack in 1st BUSY cycle:
  - wb_we_o=1, wb_dat_o=0x5A5A5A5A, wb_sel_o=4'b1000, stallreq_o high 1 cycle, cpu_data_o=0.
- Load acked while stall_i=1 for 2 more cycles, cpu_ce_i held high:
  - State HOLD; exactly one bus cycle issued; cpu_data_o=rd_buf until stall_i falls; then IDLE.
- flush_i=1 in BUSY, ack 2 cycles later with 0x12345678:
  - Bus cycle completes; cpu_data_o=0; next state IDLE; no new cycle started.
- rst=1 during BUSY:
  - Next edge: cyc/stb=0, all outputs at reset values; late wb_ack_i ignored.
- DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack:
  - err_o pulses 1 cycle at 4th BUSY cycle; cpu_data_o=0; stallreq_o drops; cyc=0 next cycle.
